// File: rtl/gfg_spi_master.sv
// SPI mode-0 master for the gfg register slave: one 40-bit {cmd, data} frame per request.
// Optional GFG_SPI_MASTER_WRITE_VERIFY_EN adds an automatic readback after every write and flags mismatches on o_err.
module gfg_spi_master #(
  parameter int CLK_DIV    = 4,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  srst_n,
  input  logic                  i_start,
  input  logic                  i_write,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_err,
  output logic                  o_spi_clk,
  output logic                  o_spi_mosi,
  input  logic                  i_spi_miso,
  output logic                  o_spi_ss_n
);

  localparam int FW    = 2 + ADDR_WIDTH + DATA_WIDTH;
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(FW);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FW - 1);
`ifdef GFG_SPI_MASTER_WRITE_VERIFY_EN
  localparam bit VERIFY_EN = 1'b1;
`else
  localparam bit VERIFY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

  state_e                 state_q, state_d;
  logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [FW-1:0]          tx_q, tx_d;
  logic [DATA_WIDTH-1:0]  rx_q, rx_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   wr_q, wr_d;
  logic                   vfy_q, vfy_d;
  logic                   sclk_q, sclk_d;
  logic                   ss_n_q, ss_n_d;
  logic                   mosi_q, mosi_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   tick;

  assign tick = (div_cnt_q == DIV_LAST);

  always_comb begin
    state_d   = state_q;
    div_cnt_d = (state_q == IDLE || tick) ? '0 : div_cnt_q + DIV_W'(1);
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rdata_d   = rdata_q;
    wdata_d   = wdata_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    vfy_d     = vfy_q;
    sclk_d    = sclk_q;
    ss_n_d    = ss_n_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: if (i_start) begin
        state_d   = SETUP;
        tx_d      = {i_write, 1'b0, i_addr, i_wdata};
        mosi_d    = i_write;
        ss_n_d    = 1'b0;
        bit_cnt_d = '0;
        wr_d      = i_write;
        vfy_d     = 1'b0;
        addr_d    = i_addr;
        wdata_d   = i_wdata;
      end
      SETUP: if (tick) state_d = SHIFT;
      SHIFT: if (tick) begin
        sclk_d = ~sclk_q;
        if (!sclk_q) begin
          rx_d = {rx_q[DATA_WIDTH-2:0], i_spi_miso};
        end else begin
          // falling edge: next bit out; zeros fill behind so MOSI ends low
          tx_d   = tx_q << 1;
          mosi_d = tx_q[FW-2];
          if (bit_cnt_q == BIT_LAST) state_d = HOLD;
          else bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
      HOLD: if (tick) begin
        state_d = GAP;
        ss_n_d  = 1'b1;
        mosi_d  = 1'b0;
      end
      GAP: if (tick) begin
        if (VERIFY_EN && wr_q && !vfy_q) begin
          state_d   = SETUP;
          tx_d      = {2'b00, addr_q, {DATA_WIDTH{1'b0}}};
          mosi_d    = 1'b0;
          ss_n_d    = 1'b0;
          bit_cnt_d = '0;
          vfy_d     = 1'b1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (!wr_q || vfy_q) rdata_d = rx_q;
          err_d   = VERIFY_EN && vfy_q && (rx_q != wdata_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!srst_n) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rdata_q   <= '0;
      wdata_q   <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      vfy_q     <= 1'b0;
      sclk_q    <= 1'b0;
      ss_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rdata_q   <= rdata_d;
      wdata_q   <= wdata_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      vfy_q     <= vfy_d;
      sclk_q    <= sclk_d;
      ss_n_q    <= ss_n_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign o_busy     = (state_q != IDLE);
  assign o_done     = done_q;
  assign o_rdata    = rdata_q;
  assign o_spi_clk  = sclk_q;
  assign o_spi_mosi = mosi_q;
  assign o_spi_ss_n = ss_n_q;
`ifdef GFG_SPI_MASTER_WRITE_VERIFY_EN
  assign o_err      = err_q;
`else
  assign o_err      = 1'b0;
`endif

endmodule

// File: tb/tb_gfg_spi_master.sv
// Scoreboard bench for gfg_spi_master: instance 0 at CLK_DIV=2, instance 1 at CLK_DIV=1, with a mode-0 slave model.
module tb_gfg_spi_master;
`ifdef GFG_SPI_MASTER_WRITE_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif

  typedef struct {
    int          inst;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          gap;
  } done_t;
  typedef struct {
    int          inst;
    logic [39:0] frame;
  } frame_t;

  logic        clk = 1'b0;
  logic        srst_n;
  logic        start [2], wr [2], busy [2], done [2], err [2];
  logic        sclk [2], mosi [2], miso [2], ss_n [2];
  logic [5:0]  addr [2];
  logic [31:0] wdata [2], rdata [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    gfg_spi_master #(.CLK_DIV(g == 0 ? 2 : 1)) u_dut (
      .i_clk(clk), .srst_n(srst_n), .i_start(start[g]), .i_write(wr[g]),
      .i_addr(addr[g]), .i_wdata(wdata[g]), .o_busy(busy[g]), .o_done(done[g]),
      .o_rdata(rdata[g]), .o_err(err[g]), .o_spi_clk(sclk[g]), .o_spi_mosi(mosi[g]),
      .i_spi_miso(miso[g]), .o_spi_ss_n(ss_n[g])
    );
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          total = 0, bad = 0;
  done_t       done_q [$];
  frame_t      frame_q [$];
  int          acc_q [$];
  logic        prev_ss [2], prev_sclk [2];
  logic [39:0] sr [2], cap [2];
  int          rises [2], badper [2], last_rise [2], gap_cnt [2], ndone [2];
  bit          abort [2];
  logic [31:0] resp [2], mdl_rdata [2];

  function automatic int dv(int g);
    return (g == 0) ? 2 : 1;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Slave model plus both scoreboard checkers, all sampled on the falling clock edge.
  task automatic monitor();
    done_t  e;
    frame_t f;
    int     a;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (!srst_n) begin
          acc_q.delete();
          abort[g]   = 1'b1;
          gap_cnt[g] = 0;
        end
        if (ss_n[g] && busy[g]) gap_cnt[g]++;
        if (done[g]) begin
          ndone[g]++;
          if (done_q.size() == 0) chk("done_unexpected", 1, 0);
          else begin
            e = done_q.pop_front();
            a = (acc_q.size() != 0) ? acc_q.pop_front() : -100000;
            chk("done_inst", 64'(g), 64'(e.inst));
            chk("done_latency", 64'(cyc - a), 64'(e.lat));
            chk("rdata", rdata[g], e.rdata);
            chk("err", err[g], e.err);
            chk("ss_gap_cycles", 64'(gap_cnt[g]), 64'(e.gap));
          end
        end
        if (srst_n && start[g] && !busy[g]) begin
          acc_q.push_back(cyc);
          gap_cnt[g] = 0;
        end
        if (prev_ss[g] && !ss_n[g]) begin
          sr[g]     = {8'h00, resp[g]};
          cap[g]    = '0;
          rises[g]  = 0;
          badper[g] = 0;
          abort[g]  = 1'b0;
        end else if (!ss_n[g] && !prev_sclk[g] && sclk[g]) begin
          cap[g] = {cap[g][38:0], mosi[g]};
          if (rises[g] > 0 && (cyc - last_rise[g]) != 2 * dv(g)) badper[g]++;
          rises[g]++;
          last_rise[g] = cyc;
        end else if (!ss_n[g] && prev_sclk[g] && !sclk[g]) begin
          sr[g] = sr[g] << 1;
        end
        if (!prev_ss[g] && ss_n[g]) begin
          if (abort[g]) abort[g] = 1'b0;
          else if (frame_q.size() == 0) chk("frame_unexpected", 1, 0);
          else begin
            f = frame_q.pop_front();
            chk("frame_inst", 64'(g), 64'(f.inst));
            chk("mosi_frame", cap[g], f.frame);
            chk("sclk_rises", 64'(rises[g]), 64'd40);
            chk("sclk_period_errs", 64'(badper[g]), 64'd0);
          end
        end
        miso[g]      = sr[g][39];
        prev_ss[g]   = ss_n[g];
        prev_sclk[g] = sclk[g];
      end
    end
  endtask

  task automatic expect_op(int g, bit w, logic [5:0] a, logic [31:0] d, logic [31:0] rsp);
    int     m;
    frame_t f;
    done_t  e;
    m = (w && VFY) ? 2 : 1;
    resp[g] = rsp;
    f.inst  = g;
    f.frame = {w, 1'b0, a, (w ? d : 32'h0)};
    frame_q.push_back(f);
    if (w && VFY) begin
      f.frame = {2'b00, a, 32'h0};
      frame_q.push_back(f);
    end
    if (!w || VFY) mdl_rdata[g] = rsp;
    e.inst  = g;
    e.lat   = 1 + 83 * dv(g) * m;
    e.rdata = mdl_rdata[g];
    e.err   = w && VFY && (rsp != d);
    e.gap   = dv(g) * m;
    done_q.push_back(e);
  endtask

  task automatic issue(int g, bit w, logic [5:0] a, logic [31:0] d);
    @(posedge clk); #1;
    start[g] = 1'b1; wr[g] = w; addr[g] = a; wdata[g] = d;
    @(posedge clk); #1;
    start[g] = 1'b0;
  endtask

  task automatic wait_idle(int g);
    int n;
    n = 0;
    while ((done_q.size() != 0 || frame_q.size() != 0 || busy[g]) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 64'(n < 3000), 64'd1);
  endtask

  initial begin
    int n, snap;
    srst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      start[g] = 0; wr[g] = 0; addr[g] = '0; wdata[g] = '0; miso[g] = 0;
      prev_ss[g] = 1'b1; prev_sclk[g] = 1'b0; sr[g] = '0; cap[g] = '0;
      rises[g] = 0; badper[g] = 0; last_rise[g] = 0; gap_cnt[g] = 0; ndone[g] = 0;
      abort[g] = 1'b1; resp[g] = '0; mdl_rdata[g] = '0;
    end
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_ss_n", ss_n[g], 1);
      chk("rst_sclk", sclk[g], 0);
      chk("rst_mosi", mosi[g], 0);
      chk("rst_busy", busy[g], 0);
      chk("rst_done", done[g], 0);
      chk("rst_err", err[g], 0);
      chk("rst_rdata", rdata[g], 0);
    end
    @(posedge clk); #1;
    srst_n = 1'b1;

    expect_op(0, 1, 6'h05, 32'hDEADBEEF, 32'hDEADBEEF);
    issue(0, 1, 6'h05, 32'hDEADBEEF);
    wait_idle(0);

    expect_op(0, 0, 6'h1F, 32'h0, 32'h12345678);
    issue(0, 0, 6'h1F, 32'h0);
    wait_idle(0);
    repeat (10) @(negedge clk);
    chk("rdata_held", rdata[0], mdl_rdata[0]);

    // back-to-back with start held; stray strobes while busy must not add frames
    expect_op(0, 1, 6'h2A, 32'h0F0F0F0F, 32'h0F0F0F0F);
    expect_op(0, 1, 6'h2A, 32'h0F0F0F0F, 32'h0F0F0F0F);
    @(posedge clk); #1;
    start[0] = 1; wr[0] = 1; addr[0] = 6'h2A; wdata[0] = 32'h0F0F0F0F;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done[0] && n < 1000);
    chk("b2b_first_done_seen", done[0], 1);
    @(posedge clk); #1;
    start[0] = 0;
    for (int k = 0; k < 2; k++) begin
      repeat (30) @(posedge clk); #1;
      start[0] = 1; wr[0] = 0; addr[0] = 6'h3F; wdata[0] = 32'hFFFF0000;
      @(posedge clk); #1;
      start[0] = 0;
    end
    wait_idle(0);
    repeat (200) @(negedge clk);

    expect_op(0, 1, 6'h11, 32'hA5A5A5A5, 32'hA5A5A5A4);
    issue(0, 1, 6'h11, 32'hA5A5A5A5);
    wait_idle(0);
    expect_op(0, 1, 6'h12, 32'h5A5A5A5A, 32'h5A5A5A5A);
    issue(0, 1, 6'h12, 32'h5A5A5A5A);
    wait_idle(0);

    // reset 50 cycles after accept: frame aborted, never completes
    snap = ndone[0];
    resp[0] = 32'hCAFEF00D;
    issue(0, 0, 6'h03, 32'h0);
    repeat (49) @(posedge clk);
    #1;
    srst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_ss_n", ss_n[0], 1);
    chk("abort_sclk", sclk[0], 0);
    chk("abort_busy", busy[0], 0);
    chk("abort_rdata", rdata[0], 0);
    chk("abort_done", done[0], 0);
    @(posedge clk); #1;
    srst_n = 1'b1;
    mdl_rdata[0] = '0;
    mdl_rdata[1] = '0;
    repeat (250) @(negedge clk);
    chk("abort_no_done", 64'(ndone[0]), 64'(snap));

    expect_op(1, 1, 6'h00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(1, 1, 6'h00, 32'hFFFFFFFF);
    wait_idle(1);
    expect_op(1, 0, 6'h07, 32'h0, 32'h80000001);
    issue(1, 0, 6'h07, 32'h0);
    wait_idle(1);

    repeat (20) @(negedge clk);
    chk("queues_drained", 64'(done_q.size() + frame_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gfg_spi_master.md
Name:
gfg_spi_master

Overview:
- SPI mode-0 master that drives the gfg SPI register slave from a host-side or loopback FPGA test harness.
- Each request becomes one 40-bit frame: an 8-bit command followed by 32 data bits, MSB first.
- Write frames load a slave register. Read frames return the register contents on o_rdata.
- Sits between a sequencer (test harness or soft CPU) and the four SPI pins of the gfg board.

Parameters:
- CLK_DIV, 4: i_clk cycles per SPI half-period; legal values 1..255.
- ADDR_WIDTH, 6: register address width; command byte = {write, 1'b0, addr[5:0]}.
- DATA_WIDTH, 32: register data width; number of data bits per frame.

Ports:
- i_clk  in  1  system clock.
- srst_n  in  1  reset; synchronous, active-low, sampled on i_clk.
- i_start  in  1  request strobe; accepted only in a cycle where o_busy=0.
- i_write  in  1  1 = write frame, 0 = read frame; latched at accept.
- i_addr  in  ADDR_WIDTH  register address; latched at accept.
- i_wdata  in  DATA_WIDTH  write data; latched at accept; ignored for reads.
- o_busy  out  1  high from the cycle after accept until the o_done cycle.
- o_done  out  1  one-cycle completion pulse.
- o_rdata  out  DATA_WIDTH  last read result; held until the next read completes.
- o_err  out  1  write-verify mismatch pulse, coincident with o_done (see Optional Feature).
- o_spi_clk  out  1  SCLK; idles low.
- o_spi_mosi  out  1  master-out data.
- i_spi_miso  in  1  slave-out data.
- o_spi_ss_n  out  1  slave select, active-low.

Behaviour:
- Reset values: o_spi_ss_n=1, o_spi_clk=0, o_spi_mosi=0, o_busy=0, o_done=0, o_err=0, o_rdata=0; state IDLE.
- Reset mid-frame: the frame is aborted on the next edge, SS_n returns high, and no o_done is produced.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE:
  - On i_start, latch shift register = {i_write, 1'b0, i_addr, i_wdata}.
  - Next cycle: state SETUP, SS_n=0, MOSI = bit 39.
- SETUP: lasts CLK_DIV cycles with SCLK low, then goes to SHIFT.
- SHIFT:
  - SCLK toggles every CLK_DIV cycles, giving 80 half-periods and 40 rising edges.
  - Rising edge: sample MISO into the receive shift register.
  - Falling edge: present the next bit on MOSI.
  - After the 40th falling edge, go to HOLD.
- HOLD: SCLK low, SS_n low for CLK_DIV cycles; then SS_n=1 and MOSI=0.
- GAP: SS_n high for CLK_DIV cycles.
- Completion:
  - o_done=1 for one cycle at accept + 1 + 83*CLK_DIV.
  - o_busy=0 in that same cycle, and a new i_start is accepted in that cycle.
- Read data:
  - The 8 bits sampled during the command phase are discarded.
  - The last 32 samples, MSB first, load o_rdata in the o_done cycle.
  - Write frames never modify o_rdata.
- i_start while busy is ignored, not queued. Input changes while busy have no effect.
- SCLK half-period counter is $clog2(CLK_DIV+1) bits. The bit counter counts 0..39 and does not wrap.

Optional Feature:
- Macro: GFG_SPI_MASTER_WRITE_VERIFY_EN.
- Defined:
  - After each write frame's GAP, the block automatically issues a read frame to the same address. o_busy stays high throughout.
  - o_done pulses only after the readback frame, at accept + 1 + 166*CLK_DIV.
  - o_rdata is loaded with the readback value.
  - o_err=1 with o_done when the readback differs from the written data.
  - Read requests behave as without the macro.
- Undefined: no readback frame is issued and o_err is tied to 0.

Test Plan:
- Write, CLK_DIV=2, addr=0x05, data=0xDEADBEEF:
  - MOSI captured on SCLK rises = 0x85 then 0xDEADBEEF.
  - Exactly 40 rises, SCLK period 4 cycles.
  - o_done at accept+167; o_rdata unchanged (0).
- Read, addr=0x1F, slave model returns 0x12345678:
  - Command byte = 0x1F.
  - o_rdata = 0x12345678 in the o_done cycle and held afterwards.
- Back-to-back:
  - i_start held high continuously → second frame accepted in the first o_done cycle.
  - SS_n high for exactly CLK_DIV cycles between frames.
  - i_start pulses while busy produce no extra frames.
- Reset: srst_n=0 at accept+50 → next cycle SS_n=1, SCLK=0, o_busy=0, o_rdata=0; no o_done ever.
- Boundary, CLK_DIV=1: write 0xFFFFFFFF to addr 0 → o_done at accept+84; SCLK toggles every cycle.
- GFG_SPI_MASTER_WRITE_VERIFY_EN defined, write 0xA5A5A5A5, slave returns 0xA5A5A5A4:
  - Two frames are sent; o_err=1 with o_done at accept+1+166*CLK_DIV.
  - With a matching slave, o_err=0.
